// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// Holds the FSM encoding, funct3 codes, load_sel codes and helper functions.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [2:0] LS_LB  = 3'b000;
    localparam logic [2:0] LS_LH  = 3'b001;
    localparam logic [2:0] LS_LBU = 3'b010;
    localparam logic [2:0] LS_LHU = 3'b011;
    localparam logic [2:0] LS_LW  = 3'b100;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic        we;
    } acc_t;

    function automatic logic [2:0] load_sel_of(input logic [2:0] f3);
        logic [2:0] sel;
        case (f3)
            F3_LB:   sel = LS_LB;
            F3_LH:   sel = LS_LH;
            F3_LBU:  sel = LS_LBU;
            F3_LHU:  sel = LS_LHU;
            default: sel = LS_LW;
        endcase
        return sel;
    endfunction

    // Unknown load codes behave as LW, unknown store codes as SW.
    function automatic logic is_aligned(input logic [2:0] f3,
                                        input logic       store,
                                        input logic [1:0] a);
        logic ok;
        if (store) begin
            case (f3)
                F3_SB:   ok = 1'b1;
                F3_SH:   ok = ~a[0];
                default: ok = (a == 2'b00);
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: ok = 1'b1;
                F3_LH, F3_LHU: ok = ~a[0];
                default:       ok = (a == 2'b00);
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_muxes.sv
// Sign/zero extension of lane-shifted load data.
// Input is already shifted so the wanted byte/half sits in the low bits.
import mem_access_ctrl_pkg::*;

module load_muxes (
    input  logic [2:0]  load_sel,
    input  logic [31:0] data,
    output logic [31:0] result
);

    always_comb begin
        result = data;
        case (load_sel)
            LS_LB:   result = {{24{data[7]}}, data[7:0]};
            LS_LH:   result = {{16{data[15]}}, data[15:0]};
            LS_LBU:  result = {24'b0, data[7:0]};
            LS_LHU:  result = {16'b0, data[15:0]};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: one load/store per access over a ready-based
// dmem port, with alignment checks, lane steering and a request timeout.
import mem_access_ctrl_pkg::*;

module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      next;
    acc_t        acc;
    logic [7:0]  cnt;
    logic        one_op;
    logic        both_op;
    logic        aligned;
    logic        start;
    logic        timeout_hit;
    logic [3:0]  be_calc;
    logic [2:0]  load_sel;
    logic [31:0] lane;
    logic [31:0] ext;

    assign one_op  = mem_read ^ mem_write;
    assign both_op = mem_read & mem_write;
    assign aligned = is_aligned(funct3, mem_write, addr[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next        = state;
        stall       = 1'b0;
        dmem_req    = 1'b0;
        start       = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (one_op && aligned) begin
                    start = 1'b1;
                    stall = 1'b1;
                    next  = REQ;
                end
            end
            REQ: begin
                stall    = 1'b1;
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    next = DONE;
                end else if (cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    next        = DONE;
                end
            end
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Byte lanes steered from the latched fields; unknown stores act as SW.
    always_comb begin
        be_calc    = 4'b1111;
        dmem_wdata = acc.sdata;
        case (acc.f3)
            F3_SB: begin
                be_calc    = 4'b0001 << acc.addr[1:0];
                dmem_wdata = {4{acc.sdata[7:0]}};
            end
            F3_SH: begin
                be_calc    = acc.addr[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{acc.sdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                dmem_wdata = acc.sdata;
            end
        endcase
    end

    assign dmem_addr = {acc.addr[31:2], 2'b00};
    assign dmem_be   = dmem_req ? be_calc : 4'b0000;
    assign dmem_we   = dmem_req & acc.we;

    assign load_sel = load_sel_of(acc.f3);

    always_comb begin
        lane = dmem_rdata;
        case (load_sel)
            LS_LB, LS_LBU: lane = dmem_rdata >> {acc.addr[1:0], 3'b000};
            LS_LH, LS_LHU: lane = dmem_rdata >> {acc.addr[1], 4'b0000};
            default:       lane = dmem_rdata;
        endcase
    end

    load_muxes u_load_muxes (
        .load_sel (load_sel),
        .data     (lane),
        .result   (ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= '0;
            cnt          <= 8'd0;
            load_data    <= 32'd0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_err <= (state == IDLE) && one_op && !aligned;
            bus_err      <= ((state == IDLE) && both_op) || timeout_hit;
            if (start) begin
                acc.f3    <= funct3;
                acc.addr  <= addr;
                acc.sdata <= store_data;
                acc.we    <= mem_write;
                cnt       <= 8'd0;
            end
            if (state == REQ) begin
                if (dmem_ready) begin
                    if (!acc.we) load_data <= ext;
                end else begin
                    cnt <= cnt + 8'd1;
                    if (timeout_hit && !acc.we) load_data <= 32'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (TIMEOUT = 15).
// Each scenario task drives one access and checks the observed behaviour.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        misalign_err, bus_err;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    int n_vec = 0;
    int n_err = 0;

    int          r_stall, r_req;
    logic        r_req_seen, r_done, r_stable, r_we, r_berr, r_merr;
    logic [31:0] r_addr, r_wdata, r_ld;
    logic [3:0]  r_be;

    mem_access_ctrl #(.TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .stall        (stall),
        .load_data    (load_data),
        .misalign_err (misalign_err),
        .bus_err      (bus_err),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata)
    );

    always #5 clk = ~clk;

    // Drives one access and records what the DUT did; ready_at is the
    // 1-based REQ cycle in which dmem_ready is raised (0 = never).
    task automatic run_access(input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input int ready_at,
                              input logic [31:0] rdata);
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3;
        addr = a; store_data = sd; dmem_ready = 1'b0;
        #1;
        r_stall = int'(stall);
        r_req_seen = dmem_req;
        r_req = 0; r_done = 1'b0; r_stable = 1'b1;
        r_berr = 1'b0; r_merr = 1'b0; r_ld = 32'hx;
        r_addr = 32'hx; r_wdata = 32'hx; r_be = 4'hx; r_we = 1'bx;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            mem_read = 1'b0; mem_write = 1'b0; dmem_ready = 1'b0;
            #1;
            if (dmem_req) r_req_seen = 1'b1;
            if (stall) begin
                r_stall++;
                r_req++;
                if (r_req == 1) begin
                    r_addr = dmem_addr; r_wdata = dmem_wdata;
                    r_be = dmem_be; r_we = dmem_we;
                end else if (dmem_addr !== r_addr || dmem_wdata !== r_wdata ||
                             dmem_be !== r_be || dmem_we !== r_we) begin
                    r_stable = 1'b0;
                end
                if (r_req == ready_at) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = rdata;
                end
            end else begin
                r_berr = bus_err; r_merr = misalign_err;
                r_ld = load_data; r_done = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; store_data = 0;
        dmem_ready = 0; dmem_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({dmem_req, dmem_we, dmem_be, misalign_err, bus_err, stall} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_ctl: got req=%b we=%b be=%b me=%b be=%b st=%b exp all 0",
                     dmem_req, dmem_we, dmem_be, misalign_err, bus_err, stall);
        end
        n_vec++;
        if ({dmem_addr, dmem_wdata, load_data} !== 96'b0) begin
            n_err++;
            $display("FAIL reset_data: got addr=%h wdata=%h ld=%h exp 0",
                     dmem_addr, dmem_wdata, load_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_lw();
        run_access(1, 0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        n_vec++;
        if (r_done !== 1'b1 || r_req !== 3 || r_stall !== 4) begin
            n_err++;
            $display("FAIL lw_timing: got done=%b req=%0d stall=%0d exp 1 3 4",
                     r_done, r_req, r_stall);
        end
        n_vec++;
        if (r_addr !== 32'h100 || r_be !== 4'b1111 || r_we !== 1'b0 || r_stable !== 1'b1) begin
            n_err++;
            $display("FAIL lw_bus: got addr=%h be=%b we=%b stable=%b exp 100 1111 0 1",
                     r_addr, r_be, r_we, r_stable);
        end
        n_vec++;
        if (r_ld !== 32'hDEADBEEF || r_berr !== 1'b0) begin
            n_err++;
            $display("FAIL lw_data: got ld=%h berr=%b exp deadbeef 0", r_ld, r_berr);
        end
    endtask

    task automatic test_load_ext();
        run_access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF0011);
        n_vec++;
        if (r_ld !== 32'hFFFFFF80 || r_stall !== 2) begin
            n_err++;
            $display("FAIL lb: got ld=%h stall=%0d exp ffffff80 2", r_ld, r_stall);
        end
        run_access(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF0011);
        n_vec++;
        if (r_ld !== 32'h00000080) begin
            n_err++;
            $display("FAIL lbu: got %h exp 00000080", r_ld);
        end
        run_access(1, 0, 3'b001, 32'h102, 32'h0, 2, 32'h80FF0011);
        n_vec++;
        if (r_ld !== 32'hFFFF80FF || r_addr !== 32'h100) begin
            n_err++;
            $display("FAIL lh: got ld=%h addr=%h exp ffff80ff 100", r_ld, r_addr);
        end
        run_access(1, 0, 3'b101, 32'h100, 32'h0, 1, 32'h80FF8011);
        n_vec++;
        if (r_ld !== 32'h00008011) begin
            n_err++;
            $display("FAIL lhu: got %h exp 00008011", r_ld);
        end
    endtask

    task automatic test_stores();
        run_access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 2, 32'hFFFFFFFF);
        n_vec++;
        if (r_addr !== 32'h200 || r_be !== 4'b1100 || r_wdata !== 32'hABCDABCD ||
            r_we !== 1'b1 || r_stable !== 1'b1) begin
            n_err++;
            $display("FAIL sh: got addr=%h be=%b wd=%h we=%b st=%b exp 200 1100 abcdabcd 1 1",
                     r_addr, r_be, r_wdata, r_we, r_stable);
        end
        n_vec++;
        if (r_ld !== 32'h00008011) begin
            n_err++;
            $display("FAIL sh_ld_hold: got %h exp 00008011", r_ld);
        end
        run_access(0, 1, 3'b000, 32'h201, 32'h0000005A, 1, 32'h0);
        n_vec++;
        if (r_be !== 4'b0010 || r_wdata !== 32'h5A5A5A5A || r_addr !== 32'h200) begin
            n_err++;
            $display("FAIL sb: got be=%b wd=%h addr=%h exp 0010 5a5a5a5a 200",
                     r_be, r_wdata, r_addr);
        end
        run_access(0, 1, 3'b010, 32'h204, 32'h13579BDF, 1, 32'h0);
        n_vec++;
        if (r_be !== 4'b1111 || r_wdata !== 32'h13579BDF || r_addr !== 32'h204) begin
            n_err++;
            $display("FAIL sw: got be=%b wd=%h addr=%h exp 1111 13579bdf 204",
                     r_be, r_wdata, r_addr);
        end
    endtask

    task automatic test_misalign();
        run_access(1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0);
        n_vec++;
        if (r_merr !== 1'b1 || r_stall !== 0 || r_req_seen !== 1'b0 || r_berr !== 1'b0) begin
            n_err++;
            $display("FAIL misalign: got merr=%b stall=%0d req=%b berr=%b exp 1 0 0 0",
                     r_merr, r_stall, r_req_seen, r_berr);
        end
        @(negedge clk); #1;
        n_vec++;
        if (misalign_err !== 1'b0 || stall !== 1'b0 || dmem_req !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_pulse: got merr=%b stall=%b req=%b exp 0 0 0",
                     misalign_err, stall, dmem_req);
        end
        run_access(0, 1, 3'b001, 32'h203, 32'h0, 1, 32'h0);
        n_vec++;
        if (r_merr !== 1'b1 || r_req_seen !== 1'b0) begin
            n_err++;
            $display("FAIL sh_misalign: got merr=%b req=%b exp 1 0", r_merr, r_req_seen);
        end
    endtask

    task automatic test_both_high();
        run_access(1, 1, 3'b010, 32'h100, 32'h0, 1, 32'h0);
        n_vec++;
        if (r_berr !== 1'b1 || r_stall !== 0 || r_req_seen !== 1'b0 || r_merr !== 1'b0) begin
            n_err++;
            $display("FAIL both_high: got berr=%b stall=%0d req=%b merr=%b exp 1 0 0 0",
                     r_berr, r_stall, r_req_seen, r_merr);
        end
        @(negedge clk); #1;
        n_vec++;
        if (bus_err !== 1'b0) begin
            n_err++;
            $display("FAIL both_high_pulse: got %b exp 0", bus_err);
        end
    endtask

    task automatic test_ready_outside();
        @(negedge clk);
        dmem_ready = 1'b1; dmem_rdata = 32'h11111111;
        #1;
        n_vec++;
        if (stall !== 1'b0 || dmem_req !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ready: got stall=%b req=%b exp 0 0", stall, dmem_req);
        end
        @(negedge clk); #1;
        n_vec++;
        if (load_data !== 32'h00008011 || dmem_req !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ready_ld: got ld=%h req=%b exp 00008011 0",
                     load_data, dmem_req);
        end
        dmem_ready = 1'b0;
    endtask

    task automatic test_timeout_edge();
        run_access(1, 0, 3'b010, 32'h300, 32'h0, 15, 32'hA5A5F00F);
        n_vec++;
        if (r_req !== 15 || r_berr !== 1'b0 || r_ld !== 32'hA5A5F00F) begin
            n_err++;
            $display("FAIL to_edge: got req=%0d berr=%b ld=%h exp 15 0 a5a5f00f",
                     r_req, r_berr, r_ld);
        end
    endtask

    task automatic test_timeout();
        run_access(1, 0, 3'b010, 32'h300, 32'h0, 0, 32'h0);
        n_vec++;
        if (r_done !== 1'b1 || r_req !== 15 || r_berr !== 1'b1 || r_ld !== 32'h0) begin
            n_err++;
            $display("FAIL timeout: got done=%b req=%0d berr=%b ld=%h exp 1 15 1 0",
                     r_done, r_req, r_berr, r_ld);
        end
        @(negedge clk); #1;
        n_vec++;
        if (bus_err !== 1'b0 || stall !== 1'b0 || dmem_req !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_idle: got berr=%b stall=%b req=%b exp 0 0 0",
                     bus_err, stall, dmem_req);
        end
    endtask

    task automatic test_reset_mid_req();
        @(negedge clk);
        mem_write = 1'b1; funct3 = 3'b010; addr = 32'h80; store_data = 32'h55;
        @(negedge clk);
        mem_write = 1'b0;
        @(negedge clk); #1;
        n_vec++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h80) begin
            n_err++;
            $display("FAIL mid_pre: got req=%b addr=%h exp 1 80", dmem_req, dmem_addr);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({dmem_req, dmem_we, dmem_be, stall, bus_err, misalign_err} !== 9'b0 ||
            {dmem_addr, dmem_wdata, load_data} !== 96'b0) begin
            n_err++;
            $display("FAIL mid_rst: got req=%b we=%b be=%b st=%b berr=%b a=%h wd=%h ld=%h exp 0",
                     dmem_req, dmem_we, dmem_be, stall, bus_err, dmem_addr, dmem_wdata, load_data);
        end
        @(negedge clk);
        rst = 1'b0;
        run_access(0, 1, 3'b010, 32'h40, 32'hCAFEF00D, 1, 32'h0);
        n_vec++;
        if (r_done !== 1'b1 || r_stall !== 2 || r_addr !== 32'h40 || r_be !== 4'b1111 ||
            r_wdata !== 32'hCAFEF00D || r_we !== 1'b1 || r_berr !== 1'b0) begin
            n_err++;
            $display("FAIL post_rst_sw: got done=%b st=%0d a=%h be=%b wd=%h we=%b berr=%b",
                     r_done, r_stall, r_addr, r_be, r_wdata, r_we, r_berr);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_stores();
        test_misalign();
        test_both_high();
        test_ready_outside();
        test_timeout_edge();
        test_timeout();
        test_reset_mid_req();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
